// File: rtl/rv64g_pkg.sv
// Shared RV64G core definitions: widths, register-file geometry and the
// write-back request record carried from execution units to the register file.
package rv64g_pkg;

    localparam int XLEN         = 64;
    localparam int NUM_REGS     = 64;
    localparam int REG_AW       = $clog2(NUM_REGS);
    localparam int NUM_WB_PORTS = 4;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rv64g_wb_arbiter_if.sv
// Write-back request bundle between the execution units and the arbiter.
// master: requesters drive valid/req and see ready; slave: the arbiter.
interface rv64g_wb_arbiter_if #(
    parameter int NUM_REQ = rv64g_pkg::NUM_WB_PORTS
) ();
    import rv64g_pkg::*;

    logic    [NUM_REQ-1:0] valid;
    wb_req_t [NUM_REQ-1:0] req;
    logic    [NUM_REQ-1:0] ready;

    modport master (output valid, output req, input ready);
    modport slave  (input valid, input req, output ready);

endinterface

// File: rtl/rv64g_rr_arbiter.sv
// Generic N-way round-robin arbiter with a hold input.
// Ports: clk_i, arst_i, req_i[N], hold_i -> gnt_o[N] (one-hot or zero).
module rv64g_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         arst_i,
    input  logic [N-1:0] req_i,
    input  logic         hold_i,
    output logic [N-1:0] gnt_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic [PW-1:0] cand;
    logic [PW-1:0] win;
    logic [N-1:0]  gnt;
    logic          found;
    int            pos;

    // Search starts at rr_ptr and wraps; the first requester seen wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        if (!hold_i && !arst_i) begin
            for (int i = 0; i < N; i++) begin
                pos  = (int'(rr_ptr_q) + i) % N;
                cand = PW'(pos);
                if (!found && req_i[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    win       = cand;
                end
            end
        end
    end

    // A grant is only issued to a valid requester, so found marks a transfer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt_o = gnt;

endmodule

// File: rtl/rv64g_wb_arbiter.sv
// Shares the register file's single unlock-write port between NUM_REQ
// write-back requesters; round-robin grant, one-cycle registered output.
// Ports: clk_i, arst_i, wb (slave bundle), hold_i, wr_unlock_en/addr/data_o,
// busy_o; with RV64G_WB_ARB_STATS_EN also grant_cnt_o per requester.
module rv64g_wb_arbiter
    import rv64g_pkg::*;
#(
    parameter  int NUM_REQ = NUM_WB_PORTS,
    localparam int NR      = NUM_REGS,
    localparam int DW      = XLEN,
    localparam int AW      = $clog2(NR)
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    rv64g_wb_arbiter_if.slave    wb,
    input  logic                 hold_i,
    output logic                 wr_unlock_en_o,
    output logic [AW-1:0]        wr_unlock_addr_o,
    output logic [DW-1:0]        wr_unlock_data_o,
    output logic                 busy_o
`ifdef RV64G_WB_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0] grant_cnt_o
`endif
);

    logic [NUM_REQ-1:0] gnt;
    logic               xfer;
    wb_req_t            sel;
    logic               en_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      data_q;

    rv64g_rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .req_i  (wb.valid),
        .hold_i (hold_i),
        .gnt_o  (gnt)
    );

    assign wb.ready = gnt;
    assign xfer     = |gnt;

    // Grant is one-hot, so a priority-free select is enough.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel = wb.req[k];
            end
        end
    end

    // x0 writes are accepted but never reach the register file.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q <= xfer && (sel.addr != '0);
            if (xfer) begin
                addr_q <= sel.addr;
                data_q <= sel.data;
            end
        end
    end

    assign wr_unlock_en_o   = en_q;
    assign wr_unlock_addr_o = addr_q;
    assign wr_unlock_data_o = data_q;
    assign busy_o           = !arst_i && ((|wb.valid) || en_q);

`ifdef RV64G_WB_ARB_STATS_EN
    logic [NUM_REQ-1:0][31:0] cnt_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (gnt[k] && (cnt_q[k] != 32'hFFFF_FFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 32'd1;
                end
            end
        end
    end

    assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_rv64g_wb_arbiter.sv
// Directed bench for rv64g_wb_arbiter: vector table plus corner sequences.
// Define RV64G_WB_ARB_STATS_EN to also cover the grant counters.
module tb_rv64g_wb_arbiter;
    import rv64g_pkg::*;

    localparam int N = 4;

    logic              clk  = 1'b0;
    logic              arst = 1'b1;
    logic              hold = 1'b0;
    logic              en;
    logic [REG_AW-1:0] waddr;
    logic [XLEN-1:0]   wdata;
    logic              busy;
`ifdef RV64G_WB_ARB_STATS_EN
    logic [N-1:0][31:0] cnt;
`endif

    rv64g_wb_arbiter_if #(.NUM_REQ(N)) wb ();

    rv64g_wb_arbiter #(
        .NUM_REQ (N)
    ) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .wb               (wb),
        .hold_i           (hold),
        .wr_unlock_en_o   (en),
        .wr_unlock_addr_o (waddr),
        .wr_unlock_data_o (wdata),
        .busy_o           (busy)
`ifdef RV64G_WB_ARB_STATS_EN
        ,
        .grant_cnt_o      (cnt)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic              m_en;
    logic [REG_AW-1:0] m_addr;
    logic [XLEN-1:0]   m_data;

    typedef struct {
        logic [N-1:0] v;
        logic         h;
        logic [N-1:0] rdy;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    // Requester protocol: a pending request stays valid and stable.
    logic    [N-1:0] pend;
    wb_req_t [N-1:0] snap;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            pend <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (pend[k]) begin
                    assert (wb.valid[k] && (wb.req[k] == snap[k]))
                    else $error("requester %0d dropped request", k);
                end
            end
            pend <= wb.valid & ~wb.ready;
            snap <= wb.req;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        arst     = 1'b1;
        hold     = 1'b0;
        wb.valid = '0;
        for (int k = 0; k < N; k++) begin
            wb.req[k].addr = REG_AW'(k + 1);
            wb.req[k].data = 64'hA0 + 64'(k);
        end
        m_en   = 1'b0;
        m_addr = '0;
        m_data = '0;
        #1;
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_ready", 64'(wb.ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_addr", 64'(waddr), 64'd0);
        chk("rst_data", wdata, 64'd0);
        @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic h,
                        input logic [N-1:0] exp_rdy, input string tag);
        @(negedge clk);
        wb.valid = v;
        hold     = h;
        #1;
        chk({tag, "_ready"}, 64'(wb.ready), 64'(exp_rdy));
        chk({tag, "_busy"}, 64'(busy), 64'((|v) | m_en));
        m_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (exp_rdy[k]) begin
                m_en   = (wb.req[k].addr != '0);
                m_addr = wb.req[k].addr;
                m_data = wb.req[k].data;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_en"}, 64'(en), 64'(m_en));
        chk({tag, "_addr"}, 64'(waddr), 64'(m_addr));
        chk({tag, "_data"}, wdata, m_data);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{4'b1111, 1'b0, 4'b0001};
        tbl[1]  = '{4'b1110, 1'b0, 4'b0010};
        tbl[2]  = '{4'b1100, 1'b0, 4'b0100};
        tbl[3]  = '{4'b1000, 1'b0, 4'b1000};
        tbl[4]  = '{4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{4'b1010, 1'b1, 4'b0000};
        tbl[6]  = '{4'b1010, 1'b0, 4'b0010};
        tbl[7]  = '{4'b1001, 1'b0, 4'b1000};
        tbl[8]  = '{4'b0001, 1'b0, 4'b0001};
        tbl[9]  = '{4'b0101, 1'b0, 4'b0100};
        tbl[10] = '{4'b0001, 1'b0, 4'b0001};

        wb.valid = '0;
        for (int k = 0; k < N; k++) wb.req[k] = '0;

        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].h, tbl[i].rdy, $sformatf("tbl%0d", i));
        end

        // Single requester k=2, then pointer must sit at 3.
        do_reset();
        wb.req[2].addr = REG_AW'(5);
        wb.req[2].data = 64'hDEAD_BEEF;
        step(4'b0100, 1'b0, 4'b0100, "single");
        step(4'b1111, 1'b0, 4'b1000, "single_ptr");

        // Round-robin under full load, then reset mid-stream.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 1'b0, N'(1) << (i % 4), $sformatf("rr%0d", i));
        end
        @(negedge clk);
        #2;
        arst = 1'b1;
        #1;
        chk("mid_rst_en", 64'(en), 64'd0);
        chk("mid_rst_ready", 64'(wb.ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", 64'(waddr), 64'd0);
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("mid_rst_first", 64'(wb.ready), 64'b0001);

        // x0 write is granted but dropped; pointer still advances.
        do_reset();
        wb.req[1].addr = '0;
        wb.req[1].data = 64'h1;
        step(4'b0010, 1'b0, 4'b0010, "x0");
        step(4'b1111, 1'b0, 4'b0100, "x0_ptr");

        // hold blocks grants but not the captured write.
        do_reset();
        step(4'b0100, 1'b0, 4'b0100, "hold_xfer");
        for (int i = 0; i < 3; i++) begin
            step(4'b1011, 1'b1, 4'b0000, $sformatf("hold%0d", i));
        end
        step(4'b1011, 1'b0, 4'b1000, "hold_rel");

`ifdef RV64G_WB_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("cnt_rst%0d", k), 64'(cnt[k]), 64'd0);
        end
        for (int i = 0; i < 10; i++) begin
            step(4'b1111, 1'b0, N'(1) << (i % 4), $sformatf("st%0d", i));
        end
        chk("cnt0", 64'(cnt[0]), 64'd3);
        chk("cnt1", 64'(cnt[1]), 64'd3);
        chk("cnt2", 64'(cnt[2]), 64'd2);
        chk("cnt3", 64'(cnt[3]), 64'd2);
`endif

        do_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
